trig_in_receiver: RTL and testbench
===================================

# trig_in_receiver

External trigger input receiver for the arbitrary function generator: the input-side counterpart of the trigger-output latency path. Synchronises the asynchronous trigger pin into the `Clock` domain and rejects glitches. Detects the selected edge, applies a programmable delay and a holdoff window, then issues a single-cycle internal trigger to the waveform sequencer. It also counts accepted triggers and flags triggers that were dropped.

## Interface
- `FILT_W`, 4: width of glitch-filter length.
- `DLY_W`, 16: width of trigger delay.
- `HO_W`, 16: width of holdoff.
- `CNT_W`, 16: width of accepted-trigger counter.

- `Clock`  in  1  sole clock; all state on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `TrigIn`  in  1  external trigger pin, asynchronous.
- `Enable`  in  1  receiver enable.
- `EdgeSel`  in  2  00 rising, 01 falling, 10 both, 11 none.
- `FiltLen`  in  FILT_W  extra stable cycles required (0 = minimum).
- `Delay`  in  DLY_W  cycles from qualified edge to `TrigOut`.
- `Holdoff`  in  HO_W  dead cycles after `TrigOut`.
- `TrigOut`  out  1  one-cycle internal trigger pulse.
- `Busy`  out  1  high when FSM is not IDLE.
- `Missed`  out  1  one-cycle pulse: qualified edge dropped.
- `TrigCount`  out  CNT_W  count of `TrigOut` pulses, wraps.

## Operation
- Sync: 2-FF chain `s1`, `s2`; runs regardless of `Enable`.
- Filter:
  - Filtered level `f` and counter `fc`.
  - If `s2 == f`, then `fc <= 0`.
  - Otherwise, if `fc >= FiltLen`, then `f <= s2` and `fc <= 0`; else `fc++`.
  - `s2` must therefore differ from `f` for `FiltLen+1` consecutive cycles.
- Edge event `ev` (combinational): `f & ~f_d` (rising), `~f & f_d` (falling), `f ^ f_d` (both), 0 (none), gated by `Enable`.
- FSM states: IDLE, DELAY, HOLDOFF.
  - IDLE + `ev`, `Delay == 0`: `TrigOut <= 1`. Then HOLDOFF if `Holdoff != 0`, else stay IDLE.
  - IDLE + `ev`, `Delay == D > 0`: load `dc <= D-1`, go to DELAY.
  - DELAY: decrement `dc`. At `dc == 0`, assert `TrigOut` and go to HOLDOFF, or IDLE if holdoff is 0.
  - HOLDOFF: counter loaded with `Holdoff-1` on entry; return to IDLE when it reaches 0.
- `Delay` and `Holdoff` are sampled only when their counter loads. Later changes do not affect the pending trigger.
- `ev` while in DELAY or HOLDOFF is ignored and produces `Missed` on the next edge.
- `Enable` low: FSM forced to IDLE next edge, pending delayed trigger cancelled, no `Missed`. `TrigCount` holds its value.
- `TrigCount` increments on every edge where `TrigOut` is registered high; wraps 2^CNT_W−1 → 0.
- `EdgeSel` change takes effect immediately. It cannot create an event without an `f` transition.

## Timing
- Reset values: `s1`, `s2`, `f`, `f_d`, `fc`, counters = 0; state IDLE; `TrigOut`, `Missed`, `Busy` = 0; `TrigCount` = 0.
- `TrigIn` held high through reset release yields one rising event after synchronisation. This is intended behaviour.
- Latency: `TrigIn` sampled high at edge k → `TrigOut` high after edge k+3+FiltLen+Delay, for exactly one cycle.
- Retrigger: `TrigOut` spacing is at least `1+Holdoff` cycles; the next `TrigOut` also requires a new `f` edge.
- Glitch rejection: pulses shorter than `FiltLen+1` cycles at `s2` are rejected.
- Reset asserted mid-DELAY: pending trigger lost; all outputs 0 asynchronously.
- `Busy` is registered with the state: high from the edge leaving IDLE to the edge returning.

## Structure
- Package `trig_in_pkg`:
  - FSM state enum (IDLE, DELAY, HOLDOFF).
  - `EdgeSel` encodings (`EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`, `EDGE_NONE`).
- Sub-module `trig_in_filter` contains the sync chain, glitch filter and `f_d`. It outputs `f` and `f_d`.
- Top level contains edge select, FSM, counters and `TrigCount`.

## Test plan
- `FiltLen`=0, `Delay`=0, `Holdoff`=0, rising; `TrigIn` 0→1 at edge 10 → `TrigOut` high exactly after edge 13; `TrigCount`=1.
- `FiltLen`=3: `TrigIn` pulse of 3 cycles → no `TrigOut`. Pulse of 4 cycles → `TrigOut` after edge k+6.
- `Delay`=5, `Holdoff`=10, both edges; second edge arrives 8 cycles after first → `Missed` pulse; only one `TrigOut`, 5 cycles after the first event.
- `Delay`=20; drop `Enable` at cycle 10 of DELAY → no `TrigOut`, no `Missed`; `Busy` low next edge.
- `CNT_W`=4: 16 spaced triggers → `TrigCount` wraps 15→0.
- `Reset_n` pulsed low mid-HOLDOFF → all outputs 0 immediately; `TrigIn` high at release → one `TrigOut` with the standard latency.

Source files
------------

// File: rtl/trig_in_pkg.sv
// Shared types for the external trigger input receiver.
package trig_in_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

endpackage

// File: rtl/trig_in_receiver_if.sv
// Control/status bundle of the trigger input receiver; master drives config and the pin.
interface trig_in_receiver_if #(
   parameter int FILT_W = 4,
   parameter int DLY_W  = 16,
   parameter int HO_W   = 16,
   parameter int CNT_W  = 16
);
   logic              TrigIn;
   logic              Enable;
   logic [1:0]        EdgeSel;
   logic [FILT_W-1:0] FiltLen;
   logic [DLY_W-1:0]  Delay;
   logic [HO_W-1:0]   Holdoff;
   logic              TrigOut;
   logic              Busy;
   logic              Missed;
   logic [CNT_W-1:0]  TrigCount;

   modport master (
      output TrigIn, Enable, EdgeSel, FiltLen, Delay, Holdoff,
      input  TrigOut, Busy, Missed, TrigCount
   );

   modport slave (
      input  TrigIn, Enable, EdgeSel, FiltLen, Delay, Holdoff,
      output TrigOut, Busy, Missed, TrigCount
   );
endinterface

// File: rtl/trig_in_filter.sv
// Two-flop synchroniser plus glitch filter; emits the filtered level and its one-cycle delay.
module trig_in_filter #(
   parameter int FILT_W = 4
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              TrigIn,
   input  logic [FILT_W-1:0] FiltLen,
   output logic              f,
   output logic              f_d
);
   logic              s1, s2;
   logic [FILT_W-1:0] fc;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         f   <= 1'b0;
         f_d <= 1'b0;
         fc  <= '0;
      end else begin
         s1  <= TrigIn;
         s2  <= s1;
         f_d <= f;
         // s2 must disagree with f for FiltLen+1 consecutive cycles before f follows
         if (s2 == f) begin
            fc <= '0;
         end else if (fc >= FiltLen) begin
            f  <= s2;
            fc <= '0;
         end else begin
            fc <= fc + FILT_W'(1);
         end
      end
   end
endmodule

// File: rtl/trig_in_receiver.sv
// External trigger receiver: edge select, delay/holdoff FSM, missed-trigger flag and trigger count.
module trig_in_receiver
   import trig_in_pkg::*;
#(
   parameter int FILT_W = 4,
   parameter int DLY_W  = 16,
   parameter int HO_W   = 16,
   parameter int CNT_W  = 16
) (
   input logic               Clock,
   input logic               Reset_n,
   trig_in_receiver_if.slave bus
);
   logic             f, f_d;
   logic             ev_sel, ev;
   state_t           state, state_nx;
   logic [DLY_W-1:0] dc, dc_nx;
   logic [HO_W-1:0]  hc, hc_nx;
   logic             trig_nx, missed_nx;
   logic             trig_q, missed_q, busy_q;
   logic [CNT_W-1:0] cnt;

   trig_in_filter #(.FILT_W(FILT_W)) u_filter (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .TrigIn  (bus.TrigIn),
      .FiltLen (bus.FiltLen),
      .f       (f),
      .f_d     (f_d)
   );

   always_comb begin
      ev_sel = 1'b0;
      case (bus.EdgeSel)
         EDGE_RISE: ev_sel = f & ~f_d;
         EDGE_FALL: ev_sel = ~f & f_d;
         EDGE_BOTH: ev_sel = f ^ f_d;
         default:   ev_sel = 1'b0;
      endcase
      ev = ev_sel & bus.Enable;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      dc_nx     = dc;
      hc_nx     = hc;
      trig_nx   = 1'b0;
      missed_nx = 1'b0;
      // Disable cancels anything pending without reporting a miss
      if (!bus.Enable) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (ev) begin
                  if (bus.Delay == '0) begin
                     trig_nx = 1'b1;
                     if (bus.Holdoff != '0) begin
                        state_nx = HOLDOFF;
                        hc_nx    = bus.Holdoff - HO_W'(1);
                     end
                  end else begin
                     state_nx = DELAY;
                     dc_nx    = bus.Delay - DLY_W'(1);
                  end
               end
            end
            DELAY: begin
               missed_nx = ev;
               if (dc == '0) begin
                  trig_nx = 1'b1;
                  if (bus.Holdoff != '0) begin
                     state_nx = HOLDOFF;
                     hc_nx    = bus.Holdoff - HO_W'(1);
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  dc_nx = dc - DLY_W'(1);
               end
            end
            HOLDOFF: begin
               missed_nx = ev;
               if (hc == '0) state_nx = IDLE;
               else          hc_nx    = hc - HO_W'(1);
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         dc       <= '0;
         hc       <= '0;
         trig_q   <= 1'b0;
         missed_q <= 1'b0;
         busy_q   <= 1'b0;
         cnt      <= '0;
      end else begin
         dc       <= dc_nx;
         hc       <= hc_nx;
         trig_q   <= trig_nx;
         missed_q <= missed_nx;
         busy_q   <= (state_nx != IDLE);
         if (trig_nx) cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.TrigOut   = trig_q;
   assign bus.Missed    = missed_q;
   assign bus.Busy      = busy_q;
   assign bus.TrigCount = cnt;
endmodule

// File: tb/tb_trig_in_receiver.sv
// Directed bench: expected TrigOut/Missed cycles are queued by stimulus, popped by a monitor.
module tb_trig_in_receiver;
   import trig_in_pkg::*;

   logic Clock   = 1'b0;
   logic Reset_n = 1'b0;

   trig_in_receiver_if #(.FILT_W(4), .DLY_W(16), .HO_W(16), .CNT_W(4)) bus ();

   trig_in_receiver #(.FILT_W(4), .DLY_W(16), .HO_W(16), .CNT_W(4)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_trig[$];
   int exp_miss[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the head of its queue; an overdue head is a miss
   always @(negedge Clock) begin
      if (Reset_n) begin
         if (bus.TrigOut === 1'b1) begin
            if (exp_trig.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL trig_unexpected: TrigOut at cycle %0d, none expected", cyc);
            end else chk("trig_cycle", cyc, exp_trig.pop_front());
         end else if (exp_trig.size() > 0 && exp_trig[0] < cyc) begin
            chk("trig_missing", cyc, exp_trig.pop_front());
         end
         if (bus.Missed === 1'b1) begin
            if (exp_miss.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL missed_unexpected: Missed at cycle %0d, none expected", cyc);
            end else chk("missed_cycle", cyc, exp_miss.pop_front());
         end else if (exp_miss.size() > 0 && exp_miss[0] < cyc) begin
            chk("missed_missing", cyc, exp_miss.pop_front());
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge Clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, r;
      bus.TrigIn  = 1'b0;
      bus.Enable  = 1'b1;
      bus.EdgeSel = EDGE_RISE;
      bus.FiltLen = '0;
      bus.Delay   = '0;
      bus.Holdoff = '0;

      wait_cyc(3);
      chk("reset_trigout", bus.TrigOut, 0);
      chk("reset_missed", bus.Missed, 0);
      chk("reset_busy", bus.Busy, 0);
      chk("reset_count", bus.TrigCount, 0);
      Reset_n = 1'b1;

      // Minimum latency: pin high at edge 10 -> TrigOut after edge 13
      wait_until(9);
      bus.TrigIn = 1'b1;
      exp_trig.push_back(13);
      wait_cyc(6);
      chk("count_first", bus.TrigCount, 1);
      bus.TrigIn = 1'b0;
      wait_cyc(6);

      // Glitch filter FiltLen=3: 3-cycle pulse rejected, 4-cycle pulse accepted
      bus.FiltLen = 4'd3;
      bus.TrigIn = 1'b1;
      wait_cyc(3);
      bus.TrigIn = 1'b0;
      wait_cyc(12);
      chk("count_glitch", bus.TrigCount, 1);
      k = cyc + 1;
      bus.TrigIn = 1'b1;
      exp_trig.push_back(k + 6);
      wait_cyc(4);
      bus.TrigIn = 1'b0;
      wait_cyc(14);
      chk("count_filtered", bus.TrigCount, 2);

      // Delay 5, holdoff 10, both edges: second edge lands in holdoff
      bus.FiltLen = '0;
      bus.Delay   = 16'd5;
      bus.Holdoff = 16'd10;
      bus.EdgeSel = EDGE_BOTH;
      k = cyc + 1;
      bus.TrigIn = 1'b1;
      exp_trig.push_back(k + 8);
      wait_until(k + 7);
      bus.TrigIn = 1'b0;
      exp_miss.push_back(k + 11);
      wait_cyc(25);
      chk("count_holdoff", bus.TrigCount, 3);

      // Enable dropped mid-delay cancels silently
      bus.Delay   = 16'd20;
      bus.Holdoff = '0;
      bus.EdgeSel = EDGE_RISE;
      k = cyc + 1;
      bus.TrigIn = 1'b1;
      wait_until(k + 12);
      chk("busy_in_delay", bus.Busy, 1);
      bus.Enable = 1'b0;
      wait_cyc(1);
      chk("busy_after_disable", bus.Busy, 0);
      wait_cyc(25);
      bus.Enable = 1'b1;
      bus.TrigIn = 1'b0;
      wait_cyc(5);
      chk("count_cancel", bus.TrigCount, 3);

      // 16 spaced triggers: 4-bit count wraps 15 -> 0
      bus.Delay = '0;
      for (int i = 0; i < 16; i++) begin
         k = cyc + 1;
         bus.TrigIn = 1'b1;
         exp_trig.push_back(k + 3);
         wait_cyc(4);
         bus.TrigIn = 1'b0;
         wait_cyc(4);
         chk("count_wrap", bus.TrigCount, (4 + i) % 16);
      end

      // Reset mid-holdoff with pin held high; one trigger after release
      bus.Holdoff = 16'd10;
      k = cyc + 1;
      bus.TrigIn = 1'b1;
      exp_trig.push_back(k + 3);
      wait_until(k + 6);
      chk("busy_in_holdoff", bus.Busy, 1);
      #2 Reset_n = 1'b0;
      #1;
      chk("async_rst_trigout", bus.TrigOut, 0);
      chk("async_rst_missed", bus.Missed, 0);
      chk("async_rst_busy", bus.Busy, 0);
      chk("async_rst_count", bus.TrigCount, 0);
      wait_cyc(2);
      Reset_n = 1'b1;
      r = cyc + 1;
      exp_trig.push_back(r + 3);
      wait_cyc(15);
      chk("count_after_reset", bus.TrigCount, 1);
      bus.TrigIn = 1'b0;
      wait_cyc(15);

      chk("trig_queue_empty", exp_trig.size(), 0);
      chk("miss_queue_empty", exp_miss.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
